// File: rtl/acc_classifier_if.sv
// CPU <-> classifier command/result bundle: operand pair in, prediction and status out.
interface acc_classifier_if;
    logic        acc_en_i;
    logic [15:0] rm_i;
    logic [15:0] rn_i;
    logic [3:0]  predict_o;
    logic        valid_o;
    logic        busy_o;
    logic        err_o;

    modport master (
        output acc_en_i, rm_i, rn_i,
        input  predict_o, valid_o, busy_o, err_o
    );

    modport slave (
        input  acc_en_i, rm_i, rn_i,
        output predict_o, valid_o, busy_o, err_o
    );
endinterface

// File: rtl/acc_classifier.sv
// Linear classifier accelerator: signed weight store, one-class-per-cycle MAC,
// sequential argmax with ties resolved to the lowest class index.
module acc_classifier #(
    parameter int unsigned NUM_CLASS = 10,
    parameter int unsigned NUM_FEAT  = 16,
    parameter int unsigned ACC_W     = 32
) (
    input  logic            clk_i,
    input  logic            rst,
    acc_classifier_if.slave bus
);
    localparam int unsigned CW = (NUM_CLASS > 1) ? $clog2(NUM_CLASS) : 1;
    localparam int unsigned FW = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1;
    localparam logic [CW-1:0] LAST_C = CW'(NUM_CLASS - 1);

    localparam logic [2:0] OP_NOP      = 3'b000;
    localparam logic [2:0] OP_LOAD_W   = 3'b001;
    localparam logic [2:0] OP_CLEAR    = 3'b010;
    localparam logic [2:0] OP_FEAT     = 3'b011;
    localparam logic [2:0] OP_CLASSIFY = 3'b100;

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_ARGMAX} state_t;

    state_t                  r_state, w_state_nxt;
    logic [CW-1:0]           r_c, w_c_nxt;
    logic [FW-1:0]           r_idx, w_idx_nxt;
    logic signed [15:0]      r_x, w_x_nxt;
    logic signed [ACC_W-1:0] r_best, w_best_nxt;
    logic [CW-1:0]           r_bidx, w_bidx_nxt;
    logic [3:0]              r_predict, w_predict_nxt;
    logic                    r_valid, w_valid_nxt;
    logic                    r_busy, w_busy_nxt;
    logic                    r_err, w_err_nxt;

    logic signed [15:0]      r_weight [NUM_CLASS][NUM_FEAT];
    logic signed [ACC_W-1:0] r_score  [NUM_CLASS];

    logic                    w_wr_en;
    logic [CW-1:0]           w_wr_cls;
    logic [FW-1:0]           w_wr_idx;
    logic                    w_sc_clr;
    logic                    w_sc_mac;
    logic signed [15:0]      w_wsel;
    logic signed [31:0]      w_prod;
    logic signed [ACC_W-1:0] w_prod_ext;
    logic                    w_gt;
    logic [CW-1:0]           w_bidx_fin;
    logic [2:0]              w_op;
    logic                    w_cls_ok;
    logic                    w_idx_ok;
    logic                    w_unused;

    assign w_op     = bus.rn_i[15:13];
    assign w_cls_ok = 32'(bus.rn_i[11:8]) < NUM_CLASS;
    assign w_idx_ok = 32'(bus.rn_i[7:0]) < NUM_FEAT;
    assign w_unused = bus.rn_i[12];

    // Product is formed at 32 bits, then resized to the accumulator width.
    assign w_wsel     = r_weight[r_c][r_idx];
    assign w_prod     = 32'(w_wsel) * 32'(r_x);
    assign w_prod_ext = ACC_W'(w_prod);

    assign w_gt       = r_score[r_c] > r_best;
    assign w_bidx_fin = w_gt ? r_c : r_bidx;

    // Next-state: engine progress first, then command decode (CLEAR overrides all).
    always_comb begin
        w_state_nxt   = r_state;
        w_c_nxt       = r_c;
        w_idx_nxt     = r_idx;
        w_x_nxt       = r_x;
        w_best_nxt    = r_best;
        w_bidx_nxt    = r_bidx;
        w_predict_nxt = r_predict;
        w_valid_nxt   = r_valid;
        w_busy_nxt    = r_busy;
        w_err_nxt     = r_err;
        w_wr_en       = 1'b0;
        w_wr_cls      = CW'(bus.rn_i[11:8]);
        w_wr_idx      = FW'(bus.rn_i[7:0]);
        w_sc_clr      = 1'b0;
        w_sc_mac      = 1'b0;

        case (r_state)
            S_MAC: begin
                w_sc_mac = 1'b1;
                if (r_c == LAST_C) begin
                    w_state_nxt = S_IDLE;
                    w_busy_nxt  = 1'b0;
                end else begin
                    w_c_nxt = r_c + CW'(1);
                end
            end
            S_ARGMAX: begin
                if (w_gt) begin
                    w_best_nxt = r_score[r_c];
                    w_bidx_nxt = r_c;
                end
                if (r_c == LAST_C) begin
                    w_predict_nxt = 4'(w_bidx_fin);
                    w_valid_nxt   = 1'b1;
                    w_busy_nxt    = 1'b0;
                    w_state_nxt   = S_IDLE;
                end else begin
                    w_c_nxt = r_c + CW'(1);
                end
            end
            default: ;
        endcase

        if (bus.acc_en_i) begin
            if (w_op == OP_CLEAR) begin
                w_sc_clr      = 1'b1;
                w_sc_mac      = 1'b0;
                w_valid_nxt   = 1'b0;
                w_predict_nxt = 4'd0;
                w_err_nxt     = 1'b0;
                w_busy_nxt    = 1'b0;
                w_state_nxt   = S_IDLE;
                w_c_nxt       = '0;
            end else if (r_busy) begin
                w_err_nxt = 1'b1;
            end else begin
                case (w_op)
                    OP_NOP: ;
                    OP_LOAD_W: begin
                        if (w_cls_ok && w_idx_ok) w_wr_en = 1'b1;
                        else                      w_err_nxt = 1'b1;
                    end
                    OP_FEAT: begin
                        if (w_idx_ok) begin
                            w_x_nxt     = bus.rm_i;
                            w_idx_nxt   = FW'(bus.rn_i[7:0]);
                            w_c_nxt     = '0;
                            w_state_nxt = S_MAC;
                            w_busy_nxt  = 1'b1;
                            w_valid_nxt = 1'b0;
                        end else begin
                            w_err_nxt = 1'b1;
                        end
                    end
                    OP_CLASSIFY: begin
                        if (NUM_CLASS == 1) begin
                            w_predict_nxt = 4'd0;
                            w_valid_nxt   = 1'b1;
                        end else begin
                            w_state_nxt = S_ARGMAX;
                            w_c_nxt     = CW'(1);
                            w_best_nxt  = r_score[0];
                            w_bidx_nxt  = '0;
                            w_busy_nxt  = 1'b1;
                        end
                    end
                    default: w_err_nxt = 1'b1;
                endcase
            end
        end
    end

    // State, status, weight store and score registers.
    always_ff @(posedge clk_i) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_c       <= '0;
            r_idx     <= '0;
            r_x       <= '0;
            r_best    <= '0;
            r_bidx    <= '0;
            r_predict <= 4'd0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_err     <= 1'b0;
            for (int unsigned i = 0; i < NUM_CLASS; i++) begin
                r_score[CW'(i)] <= '0;
                for (int unsigned j = 0; j < NUM_FEAT; j++)
                    r_weight[CW'(i)][FW'(j)] <= '0;
            end
        end else begin
            r_state   <= w_state_nxt;
            r_c       <= w_c_nxt;
            r_idx     <= w_idx_nxt;
            r_x       <= w_x_nxt;
            r_best    <= w_best_nxt;
            r_bidx    <= w_bidx_nxt;
            r_predict <= w_predict_nxt;
            r_valid   <= w_valid_nxt;
            r_busy    <= w_busy_nxt;
            r_err     <= w_err_nxt;
            if (w_wr_en) r_weight[w_wr_cls][w_wr_idx] <= bus.rm_i;
            if (w_sc_clr) begin
                for (int unsigned i = 0; i < NUM_CLASS; i++) r_score[CW'(i)] <= '0;
            end else if (w_sc_mac) begin
                r_score[r_c] <= r_score[r_c] + w_prod_ext;
            end
        end
    end

    assign bus.predict_o = r_predict;
    assign bus.valid_o   = r_valid;
    assign bus.busy_o    = r_busy;
    assign bus.err_o     = r_err;
endmodule

// File: tb/tb_acc_classifier.sv
// Bench for acc_classifier: directed table, timing sequences, random commands vs. a score model.
module tb_acc_classifier;
    localparam int NC = 10;
    localparam int NF = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    acc_classifier_if bus ();

    acc_classifier #(.NUM_CLASS(NC), .NUM_FEAT(NF), .ACC_W(32)) dut (
        .clk_i (clk),
        .rst   (rst),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: scores update atomically on FEAT; only busy/result timing is cycle-counted.
    int       m_w [NC][NF];
    int       m_s [NC];
    int       m_pred, m_valid, m_err;
    int       m_rem;
    bit       m_pend;
    int       m_pend_pred;

    function automatic int argmax();
        int best = m_s[0];
        int bi = 0;
        for (int c = 1; c < NC; c++)
            if (m_s[c] > best) begin best = m_s[c]; bi = c; end
        return bi;
    endfunction

    task automatic m_reset();
        for (int c = 0; c < NC; c++) begin
            m_s[c] = 0;
            for (int f = 0; f < NF; f++) m_w[c][f] = 0;
        end
        m_pred = 0; m_valid = 0; m_err = 0; m_rem = 0; m_pend = 0; m_pend_pred = 0;
    endtask

    task automatic m_step(input logic en, input logic [15:0] rn, input logic [15:0] rm);
        bit busy_now = (m_rem > 0);
        int op  = int'(rn[15:13]);
        int cls = int'(rn[11:8]);
        int idx = int'(rn[7:0]);
        int val = int'($signed(rm));
        if (en && op == 2) begin
            for (int c = 0; c < NC; c++) m_s[c] = 0;
            m_pred = 0; m_valid = 0; m_err = 0; m_rem = 0; m_pend = 0;
            return;
        end
        if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0 && m_pend) begin m_pred = m_pend_pred; m_valid = 1; m_pend = 0; end
        end
        if (!en) return;
        if (busy_now) begin m_err = 1; return; end
        case (op)
            0: ;
            1: if (cls < NC && idx < NF) m_w[cls][idx] = val; else m_err = 1;
            3: if (idx < NF) begin
                   for (int c = 0; c < NC; c++) m_s[c] = m_s[c] + m_w[c][idx] * val;
                   m_valid = 0;
                   m_rem = NC;
               end else m_err = 1;
            4: begin
                   m_pend_pred = argmax();
                   if (NC == 1) begin m_pred = m_pend_pred; m_valid = 1; end
                   else begin m_rem = NC - 1; m_pend = 1; end
               end
            default: m_err = 1;
        endcase
    endtask

    // One clock: drive at negedge, model steps at posedge, returns at the next negedge.
    task automatic cyc(input logic en, input logic [15:0] rn, input logic [15:0] rm);
        bus.acc_en_i = en;
        bus.rn_i     = rn;
        bus.rm_i     = rm;
        @(posedge clk);
        if (rst) m_reset(); else m_step(en, rn, rm);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 16'h0000, 16'h0000);
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_out(input string name, input int p, input int v, input int b, input int e);
        check({name, ".predict"}, int'(bus.predict_o), p);
        check({name, ".valid"},   int'(bus.valid_o),   v);
        check({name, ".busy"},    int'(bus.busy_o),    b);
        check({name, ".err"},     int'(bus.err_o),     e);
    endtask

    task automatic check_model(input string name);
        check_out(name, m_pred, m_valid, (m_rem > 0) ? 1 : 0, m_err);
    endtask

    typedef struct {
        logic [15:0] rn;
        logic [15:0] rm;
        int          e_pred;
        int          e_valid;
        int          e_err;
    } vec_t;

    vec_t vecs [16];

    initial begin
        int cnt;
        int op_sel;
        logic [15:0] rn, rm;

        vecs[0]  = '{16'h8000, 16'h0000, 0, 1, 0};  // CLASSIFY on all-zero scores
        vecs[1]  = '{16'h2300, 16'h0005, 0, 1, 0};  // w[3][0]=5
        vecs[2]  = '{16'h2700, 16'h0004, 0, 1, 0};  // w[7][0]=4
        vecs[3]  = '{16'h6000, 16'h000A, 0, 0, 0};  // FEAT idx0 x=10
        vecs[4]  = '{16'h8000, 16'h0000, 3, 1, 0};  // scores 50/40
        vecs[5]  = '{16'h4000, 16'h0000, 0, 0, 0};  // CLEAR
        vecs[6]  = '{16'h2201, 16'hFFFD, 0, 0, 0};  // w[2][1]=-3
        vecs[7]  = '{16'h2501, 16'hFFFD, 0, 0, 0};  // w[5][1]=-3
        vecs[8]  = '{16'h6001, 16'hFFF9, 0, 0, 0};  // FEAT idx1 x=-7
        vecs[9]  = '{16'h8000, 16'h0000, 2, 1, 0};  // tie 21/21 -> lowest
        vecs[10] = '{16'h2C00, 16'h0001, 2, 1, 1};  // cls 12 out of range
        vecs[11] = '{16'h6014, 16'h0001, 2, 1, 1};  // idx 20 out of range
        vecs[12] = '{16'h8000, 16'h0000, 2, 1, 1};  // scores unchanged
        vecs[13] = '{16'hE000, 16'h0000, 2, 1, 1};  // illegal opcode
        vecs[14] = '{16'h4000, 16'h0000, 0, 0, 0};  // CLEAR
        vecs[15] = '{16'h0000, 16'h0000, 0, 0, 0};  // NOP

        bus.acc_en_i = 1'b0;
        bus.rn_i     = '0;
        bus.rm_i     = '0;
        m_reset();

        // Reset wins over a FEAT presented at the same time.
        @(negedge clk);
        rst = 1'b1;
        cyc(1'b1, 16'h6000, 16'h0005);
        cyc(1'b1, 16'h6000, 16'h0005);
        rst = 1'b0;
        check_out("reset", 0, 0, 0, 0);

        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, vecs[i].rn, vecs[i].rm);
            idle(NC + 1);
            check_out($sformatf("vec%0d", i), vecs[i].e_pred, vecs[i].e_valid, 0, vecs[i].e_err);
        end

        // FEAT busy window and CLASSIFY result latency.
        cyc(1'b1, 16'h6000, 16'h000A);
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            if (bus.busy_o) cnt++;
            cyc(1'b0, 16'h0000, 16'h0000);
        end
        check("feat_busy_cycles", cnt, 10);
        cyc(1'b1, 16'h8000, 16'h0000);
        idle(8);
        check_out("classify_t8", 0, 0, 1, 0);
        idle(1);
        check_out("classify_t9", 3, 1, 0, 0);
        check_model("classify_model");

        // Second FEAT at T+4 must be dropped and flagged.
        cyc(1'b1, 16'h4000, 16'h0000);
        cyc(1'b1, 16'h6000, 16'h000A);
        idle(3);
        cyc(1'b1, 16'h6001, 16'hFF9C);
        check("collide.err", int'(bus.err_o), 1);
        check("collide.busy", int'(bus.busy_o), 1);
        idle(NC + 1);
        cyc(1'b1, 16'h8000, 16'h0000);
        idle(NC);
        check_out("collide.single_mac", 3, 1, 0, 1);
        check_model("collide_model");
        cyc(1'b1, 16'h4000, 16'h0000);
        check_out("collide.clear", 0, 0, 0, 0);

        // CLEAR at T+5 of a CLASSIFY aborts it; weights survive.
        cyc(1'b1, 16'h6000, 16'h000A);
        idle(NC + 1);
        cyc(1'b1, 16'h8000, 16'h0000);
        idle(NC);
        check_out("abort.pre", 3, 1, 0, 0);
        cyc(1'b1, 16'h8000, 16'h0000);
        idle(4);
        cyc(1'b1, 16'h4000, 16'h0000);
        check_out("abort.now", 0, 0, 0, 0);
        idle(12);
        check_out("abort.later", 0, 0, 0, 0);
        cyc(1'b1, 16'h6000, 16'h000A);
        idle(NC + 1);
        cyc(1'b1, 16'h8000, 16'h0000);
        idle(NC);
        check_out("abort.redo", 3, 1, 0, 0);

        // Accumulator wraps: class 0 goes negative after three large products.
        cyc(1'b1, 16'h4000, 16'h0000);
        cyc(1'b1, 16'h2002, 16'h7FFF);
        cyc(1'b1, 16'h2102, 16'h0001);
        for (int r = 0; r < 3; r++) begin
            cyc(1'b1, 16'h6002, 16'h7FFF);
            idle(NC + 1);
        end
        cyc(1'b1, 16'h8000, 16'h0000);
        idle(NC);
        check_out("wrap", 1, 1, 0, 0);
        check_model("wrap_model");

        // Random command stream against the model, outputs compared every cycle.
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 4) == 0) begin
                op_sel = int'($urandom_range(0, 19));
                rm = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($signed(int'($urandom_range(0, 8)) - 4));
                if (op_sel < 7)       rn = {3'b001, 1'b0, 4'($urandom_range(0, 11)), 8'($urandom_range(0, 17))};
                else if (op_sel < 12) rn = {3'b011, 5'd0, 8'($urandom_range(0, 17))};
                else if (op_sel < 16) rn = 16'h8000;
                else if (op_sel < 17) rn = 16'h4000;
                else if (op_sel < 18) rn = 16'h0000;
                else                  rn = {3'($urandom_range(5, 7)), 13'($urandom)};
                cyc(1'b1, rn, rm);
            end else begin
                cyc(1'b0, 16'($urandom), 16'($urandom));
            end
            check_model($sformatf("rand%0d", k));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
